alu_seq: RTL and testbench

- Parametrised, multi-cycle successor of the team's 16-bit combinational ALU, sitting between the register file and the writeback stage.
- Keeps the existing opcode map, adds an iterative multiplier, and registers all results and flags.
- Uses a valid/ready input handshake and a one-cycle out_valid pulse.
- Shifts and multiplies run bit-serially, so no barrel shifter or array multiplier is needed.

---
 rtl/alu_seq.sv | 182 ++++++++++++++++++
 tb/tb_alu_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic ops plus bit-serial shifter and shift-add multiplier.
// Results and S/Z/C/V flags are registered and announced by a one-cycle out_valid pulse.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [SHW-1:0]   d,
  input  logic [WIDTH-1:0] alu_in_a,
  input  logic [WIDTH-1:0] alu_in_b,
  output logic [WIDTH-1:0] alu_out,
  output logic             out_valid,
  output logic             S,
  output logic             Z,
  output logic             C,
  output logic             V
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_CMP = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_SLR = 4'd9;
  localparam logic [3:0] OP_SRL = 4'd10;
  localparam logic [3:0] OP_SRA = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12;
  localparam int         MSB    = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

  state_t             state, state_next;
  logic [3:0]         op_q;
  logic [SHW:0]       cnt_q;
  logic [WIDTH-1:0]   sh_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               accept;
  logic               is_shift;
  logic [WIDTH:0]     sum, diff, mul_add;
  logic [WIDTH-1:0]   sh_step, hi_n, lo_n;
  logic               sh_c;
  logic               wr, wr_out;
  logic [WIDTH-1:0]   res;
  logic               c_n, v_n;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign is_shift = (opcode[3:2] == 2'b10);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    wr         = 1'b0;
    wr_out     = 1'b0;
    res        = '0;
    c_n        = 1'b0;
    v_n        = 1'b0;
    sum        = {1'b0, alu_in_a} + {1'b0, alu_in_b};
    diff       = {1'b0, alu_in_a} - {1'b0, alu_in_b};

    // One serial shift step; sh_c is the bit leaving the register.
    sh_step = sh_q;
    sh_c    = 1'b0;
    case (op_q)
      OP_SLL: begin sh_step = {sh_q[MSB-1:0], 1'b0};     sh_c = sh_q[MSB]; end
      OP_SLR: begin sh_step = {sh_q[MSB-1:0], sh_q[MSB]}; sh_c = 1'b0;     end
      OP_SRL: begin sh_step = {1'b0, sh_q[MSB:1]};        sh_c = sh_q[0];   end
      OP_SRA: begin sh_step = {sh_q[MSB], sh_q[MSB:1]};   sh_c = sh_q[0];   end
      default: ;
    endcase

    // One shift-add step: conditionally add multiplicand to the high half, then shift right.
    mul_add = lo_q[0] ? ({1'b0, hi_q} + {1'b0, mcand_q}) : {1'b0, hi_q};
    hi_n    = mul_add[WIDTH:1];
    lo_n    = {mul_add[0], lo_q[MSB:1]};

    case (state)
      IDLE: begin
        if (in_valid) begin
          if (opcode == OP_MUL) begin
            state_next = MUL;
          end else if (is_shift && d != '0) begin
            state_next = SHIFT;
          end else begin
            wr     = 1'b1;
            wr_out = (opcode != OP_CMP);
            case (opcode)
              OP_ADD: begin
                res = sum[MSB:0];
                c_n = sum[WIDTH];
                v_n = (alu_in_a[MSB] == alu_in_b[MSB]) && (sum[MSB] != alu_in_a[MSB]);
              end
              OP_SUB, OP_CMP: begin
                res = diff[MSB:0];
                c_n = diff[WIDTH];
                v_n = (alu_in_a[MSB] != alu_in_b[MSB]) && (diff[MSB] != alu_in_a[MSB]);
              end
              OP_AND: res = alu_in_a & alu_in_b;
              OP_OR:  res = alu_in_a | alu_in_b;
              OP_XOR: res = alu_in_a ^ alu_in_b;
              OP_MOV: res = alu_in_b;
              OP_SLL, OP_SLR, OP_SRL, OP_SRA: res = alu_in_a;
              default: res = '0;
            endcase
          end
        end
      end
      SHIFT: begin
        if (cnt_q == (SHW+1)'(1)) begin
          wr         = 1'b1;
          wr_out     = 1'b1;
          res        = sh_step;
          c_n        = sh_c;
          state_next = IDLE;
        end
      end
      MUL: begin
        if (cnt_q == (SHW+1)'(1)) begin
          wr         = 1'b1;
          wr_out     = 1'b1;
          res        = lo_n;
          c_n        = |hi_n;
          v_n        = |hi_n;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      alu_out   <= '0;
      S         <= 1'b0;
      Z         <= 1'b0;
      C         <= 1'b0;
      V         <= 1'b0;
    end else begin
      state     <= state_next;
      out_valid <= wr;
      if (wr) begin
        if (wr_out) alu_out <= res;
        S <= res[MSB];
        Z <= (res == '0);
        C <= c_n;
        V <= v_n;
      end
    end
  end

  // NOTE: working registers need no reset; they are always loaded on accept before being used.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= opcode;
      cnt_q   <= (opcode == OP_MUL) ? (SHW+1)'(WIDTH) : {1'b0, d};
      sh_q    <= alu_in_a;
      mcand_q <= alu_in_a;
      hi_q    <= '0;
      lo_q    <= alu_in_b;
    end else if (state == SHIFT) begin
      sh_q  <= sh_step;
      cnt_q <= cnt_q - (SHW+1)'(1);
    end else if (state == MUL) begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q - (SHW+1)'(1);
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: cycle-level behavioural model compared every cycle,
// plus hand-computed expectations for the directed vectors.
module tb_alu_seq;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    opcode;
  logic [3:0]    d;
  logic [W-1:0]  alu_in_a, alu_in_b;
  logic [W-1:0]  alu_out;
  logic          out_valid, S, Z, C, V;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(W), .SHW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .d(d), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
    .alu_out(alu_out), .out_valid(out_valid), .S(S), .Z(Z), .C(C), .V(V)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the opcode definitions.
  function automatic void compute(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [3:0] dd, output logic [W-1:0] r,
                                  output logic wr_out, output logic c, output logic v);
    int unsigned ua = a;
    int unsigned ub = b;
    int unsigned full;
    int          sh = dd;
    r = '0; wr_out = 1'b1; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin
        full = ua + ub; r = W'(full); c = (full > 32'hFFFF);
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'd1, 4'd5: begin
        r = a - b; c = (ua < ub);
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        wr_out = (op != 4'd5);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd6: r = b;
      4'd8:  begin r = a << sh; c = (sh != 0) ? a[W-sh] : 1'b0; end
      4'd9:  r = (sh == 0) ? a : W'((a << sh) | (a >> (W - sh)));
      4'd10: begin r = a >> sh; c = (sh != 0) ? a[sh-1] : 1'b0; end
      4'd11: begin r = W'($signed(a) >>> sh); c = (sh != 0) ? a[sh-1] : 1'b0; end
      4'd12: begin full = ua * ub; r = W'(full); c = (full >> W) != 0; v = c; end
      default: r = '0;
    endcase
  endfunction

  // Model state: what the outputs must be in the current cycle.
  logic          m_on = 1'b0;
  logic          m_ready, m_valid;
  logic [W-1:0]  m_out;
  logic [3:0]    m_flags;
  int            m_rem;
  logic [W-1:0]  p_r;
  logic          p_wr, p_c, p_v;

  function automatic void apply();
    m_valid = 1'b1;
    m_ready = 1'b1;
    if (p_wr) m_out = p_r;
    m_flags = {p_r[W-1], p_r == '0, p_c, p_v};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_on = 1'b1; m_ready = 1'b1; m_valid = 1'b0; m_out = '0; m_flags = '0; m_rem = 0;
    end else if (m_on) begin
      m_valid = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) apply();
      end else if (in_valid) begin
        compute(opcode, alu_in_a, alu_in_b, d, p_r, p_wr, p_c, p_v);
        if (opcode == 4'd12) m_rem = W;
        else if (opcode >= 4'd8 && opcode <= 4'd11) m_rem = d;
        else m_rem = 0;
        if (m_rem == 0) apply();
        else m_ready = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      check("model in_ready", in_ready, m_ready);
      check("model out_valid", out_valid, m_valid);
      check("model alu_out", alu_out, m_out);
      check("model flags SZCV", {S, Z, C, V}, m_flags);
    end
  end

  // Present one request for a single edge; operands are scrambled afterwards.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] dd);
    in_valid = 1'b1; opcode = op; alu_in_a = a; alu_in_b = b; d = dd;
    @(posedge clk); #1;
    in_valid = 1'b0; alu_in_a = 16'hDEAD; alu_in_b = 16'hBEEF; d = 4'hF; opcode = 4'hC;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("completion timeout", out_valid, 1'b1);
  endtask

  task automatic expect_lit(input string name, input logic [W-1:0] out, input logic [3:0] szcv);
    check({name, " alu_out"}, alu_out, out);
    check({name, " SZCV"}, {S, Z, C, V}, szcv);
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic [3:0]   dd;
  } vec_t;

  vec_t extra[$] = '{
    '{4'd4,  16'hF0F0, 16'h0FF0, 4'd0},
    '{4'd3,  16'h1200, 16'h0034, 4'd0},
    '{4'd2,  16'hFF00, 16'h0F0F, 4'd0},
    '{4'd6,  16'h0000, 16'hABCD, 4'd0},
    '{4'd7,  16'h1234, 16'h5678, 4'd0},
    '{4'd14, 16'h1234, 16'h5678, 4'd0},
    '{4'd0,  16'hFFFF, 16'h0001, 4'd0},
    '{4'd1,  16'h8000, 16'h0001, 4'd0},
    '{4'd10, 16'hC003, 16'h0000, 4'd15},
    '{4'd8,  16'h0003, 16'h0000, 4'd15},
    '{4'd11, 16'h7FFF, 16'h0000, 4'd3},
    '{4'd9,  16'h1234, 16'h0000, 4'd12},
    '{4'd12, 16'hFFFF, 16'hFFFF, 4'd0},
    '{4'd12, 16'h00FF, 16'h0101, 4'd0}
  };

  initial begin
    int n;
    int pulses;
    rst = 1'b1; in_valid = 1'b0; opcode = '0; d = '0; alu_in_a = '0; alu_in_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("reset in_ready", in_ready, 1'b1);
    check("reset out_valid", out_valid, 1'b0);
    expect_lit("reset", 16'h0000, 4'b0000);

    issue(4'd0, 16'h7FFF, 16'h0001, 4'd0);
    wait_done(n);
    check("add latency", n, 0);
    check("add in_ready", in_ready, 1'b1);
    expect_lit("add", 16'h8000, 4'b1001);

    issue(4'd1, 16'h0000, 16'h0001, 4'd0);
    wait_done(n);
    expect_lit("sub", 16'hFFFF, 4'b1010);

    issue(4'd5, 16'h0005, 16'h0005, 4'd0);
    wait_done(n);
    expect_lit("cmp", 16'hFFFF, 4'b0100);

    issue(4'd11, 16'h8008, 16'h0000, 4'd4);
    for (int i = 1; i <= 4; i++) begin
      check("sra busy in_ready", in_ready, 1'b0);
      in_valid = 1'b1; opcode = 4'd0; alu_in_a = 16'h1111; alu_in_b = 16'h2222;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_done(n);
    check("sra latency", n, 0);
    expect_lit("sra", 16'hF800, 4'b1010);

    issue(4'd9, 16'h8001, 16'h0000, 4'd1);
    wait_done(n);
    check("slr latency", n, 1);
    expect_lit("slr", 16'h0003, 4'b0000);

    issue(4'd8, 16'h8001, 16'h0000, 4'd0);
    wait_done(n);
    check("sll d0 latency", n, 0);
    expect_lit("sll d0", 16'h8001, 4'b1000);

    issue(4'd8, 16'h4000, 16'h0000, 4'd2);
    wait_done(n);
    expect_lit("sll d2", 16'h0000, 4'b0110);

    issue(4'd12, 16'h0100, 16'h0100, 4'd0);
    wait_done(n);
    check("mul latency", n, 16);
    expect_lit("mul ovf", 16'h0000, 4'b0111);

    issue(4'd12, 16'h0012, 16'h0034, 4'd0);
    wait_done(n);
    expect_lit("mul", 16'h03A8, 4'b0000);

    foreach (extra[i]) begin
      issue(extra[i].op, extra[i].a, extra[i].b, extra[i].dd);
      wait_done(n);
    end

    issue(4'd12, 16'h1234, 16'h5678, 4'd0);
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort out_valid", out_valid, 1'b0);
    check("abort in_ready", in_ready, 1'b1);
    expect_lit("abort", 16'h0000, 4'b0000);
    pulses = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) pulses++;
    end
    check("abort no late out_valid", pulses, 0);

    issue(4'd0, 16'h0002, 16'h0003, 4'd0);
    wait_done(n);
    expect_lit("add after abort", 16'h0005, 4'b0000);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
